// File: rtl/spike_isi_encoder.sv
// rtl/spike_isi_encoder.sv - threshold spike detector with ISI record FIFO and windowed spike rate

module spike_isi_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         drop
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             pop;
  logic             wr_en;

  assign full  = (count == FULL_CNT);
  assign valid = (count != '0);
  assign data  = mem[rd_ptr];
  assign pop   = valid && ready;
  // A pop on the same edge frees the slot, so a push into a full buffer still lands.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module spike_isi_encoder #(
  parameter int ISI_W      = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int WIN_LOG2   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [7:0]       sample_in,
  input  logic [7:0]       threshold,
  input  logic [3:0]       hyst,
  output logic [ISI_W-1:0] isi_data,
  output logic             isi_valid,
  input  logic             isi_ready,
  output logic             spike,
  output logic [7:0]       rate,
  output logic             ovf,
  input  logic             clr_ovf
);
  localparam logic [ISI_W-1:0] CNT_MAX = '1;
  localparam logic [ISI_W-1:0] CNT_ONE = {{(ISI_W-1){1'b0}}, 1'b1};

  typedef enum logic {ARMED = 1'b0, REFRACT = 1'b1} det_state_t;

  det_state_t          state;
  logic [ISI_W-1:0]    cnt;
  logic                has_prev;
  logic signed [8:0]   sample_ext;
  logic signed [8:0]   rearm_lvl;
  logic                spike_det;
  logic                rearm;
  logic                push;
  logic                drop;
  logic [WIN_LOG2-1:0] win_cnt;
  logic [7:0]          win_spikes;
  logic [7:0]          win_next;

  // Re-arm level is computed one bit wider so threshold - hyst never wraps.
  assign sample_ext = {sample_in[7], sample_in};
  assign rearm_lvl  = $signed({threshold[7], threshold}) - $signed({5'b0, hyst});
  assign spike_det  = ena && (state == ARMED) && ($signed(sample_in) > $signed(threshold));
  assign rearm      = ena && (state == REFRACT) && (sample_ext < rearm_lvl);
  assign push       = spike_det && has_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARMED;
      cnt      <= '0;
      has_prev <= 1'b0;
      spike    <= 1'b0;
    end else begin
      spike <= spike_det;
      if (spike_det)  state <= REFRACT;
      else if (rearm) state <= ARMED;
      if (ena) begin
        if (spike_det) begin
          cnt      <= CNT_ONE;
          has_prev <= 1'b1;
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  spike_isi_fifo #(.W(ISI_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (cnt),
    .ready     (isi_ready),
    .data      (isi_data),
    .valid     (isi_valid),
    .drop      (drop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (clr_ovf) ovf <= 1'b0;
  end

  // The spike on the wrapping sample still belongs to the window being closed.
  assign win_next = (spike_det && (win_spikes != 8'hFF)) ? win_spikes + 8'd1 : win_spikes;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt    <= '0;
      win_spikes <= '0;
      rate       <= '0;
    end else if (ena) begin
      win_cnt <= win_cnt + 1'b1;
      if (&win_cnt) begin
        rate       <= win_next;
        win_spikes <= '0;
      end else begin
        win_spikes <= win_next;
      end
    end
  end
endmodule
